seq_alu: RTL and testbench

Parametrised, registered successor to the CPU's combinational ALU. Covers the arithmetic, logic and shift operations and adds a multi-cycle unsigned shift-add multiplier, which replaces the external multiplier. A start/busy/done handshake connects it to the control sequencer in place of the exec1 timing signal. Results and status flags are registered and held until the next completion.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/shift_add_mul.sv | 45 ++++
 rtl/seq_alu.sv | 171 +++++++++++++++++
 tb/tb_seq_alu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, flag bit
// positions and the controller state type.
package alu_pkg;

  localparam logic [4:0] OP_MOV  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADC  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SBC  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_INV  = 5'd8;
  localparam logic [4:0] OP_TWC  = 5'd9;
  localparam logic [4:0] OP_INC  = 5'd10;
  localparam logic [4:0] OP_DEC  = 5'd11;
  localparam logic [4:0] OP_LSR  = 5'd12;
  localparam logic [4:0] OP_ASR  = 5'd13;
  localparam logic [4:0] OP_MULU = 5'd14;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial-product step per
// cycle; the caller sequences load/step and flags the final step with last.
module shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               last,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product_next,
  output logic               complete
);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     partial;

  // The multiplier occupies the low half and is consumed LSB first while the
  // accumulated sum shifts in from the top, so after WIDTH steps the whole
  // register holds the product.
  always_comb begin
    partial = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0]) begin
      partial = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
    product_next = {partial, product[WIDTH-1:1]};
    complete     = step && last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      product <= '0;
    end else if (load) begin
      mcand   <= multiplicand;
      product <= {{WIDTH{1'b0}}, multiplier};
    end else if (step) begin
      product <= product_next;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle arithmetic/logic/shift ops and a
// multi-cycle unsigned multiply behind a start/busy/done handshake.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH);

  alu_state_t state, state_d;
  logic [CW-1:0] count;
  logic          last;
  logic          mul_load, mul_step, mul_complete, accept_single;
  logic [2*WIDTH-1:0] prod_next;

  logic [WIDTH-1:0] add_a, add_b, alu_lo;
  logic             add_ci, add_v, alu_c, alu_v, illegal;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;

  // Every add-type op is a single adder with operand/carry steering, which
  // keeps the carry and overflow definitions identical across them.
  always_comb begin
    add_a  = a;
    add_b  = b;
    add_ci = 1'b0;
    case (op)
      OP_ADC: add_ci = cin;
      OP_SUB: begin add_b = ~b; add_ci = 1'b1; end
      OP_SBC: begin add_b = ~b; add_ci = cin; end
      OP_INC: add_b = WIDTH'(1);
      OP_DEC: begin add_b = ~WIDTH'(1); add_ci = 1'b1; end
      OP_TWC: begin add_a = '0; add_b = ~a; add_ci = 1'b1; end
      default: ;
    endcase
    sum   = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
    add_v = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
  end

  always_comb begin
    alu_lo  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_MOV: alu_lo = a;
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_XOR: alu_lo = a ^ b;
      OP_INV: alu_lo = ~a;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_TWC, OP_INC, OP_DEC: begin
        alu_lo = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_v  = add_v;
      end
      OP_LSR: begin alu_lo = {1'b0, a[WIDTH-1:1]}; alu_c = a[0]; end
      OP_ASR: begin alu_lo = {a[WIDTH-1], a[WIDTH-1:1]}; alu_c = a[0]; end
      default: illegal = 1'b1;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_lo == '0);
    alu_flags[FLAG_N] = alu_lo[WIDTH-1];
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
    if (illegal) begin
      alu_flags = 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Start is only looked at in IDLE, so requests during a multiply vanish.
  always_comb begin
    state_d       = state;
    mul_load      = 1'b0;
    mul_step      = 1'b0;
    accept_single = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            accept_single = 1'b1;
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign last = (count == CW'(WIDTH-1));
  assign busy = (state == ST_MUL);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (mul_load) begin
      count <= '0;
    end else if (mul_step) begin
      count <= count + CW'(1);
    end
  end

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .reset        (reset),
    .load         (mul_load),
    .step         (mul_step),
    .last         (last),
    .multiplicand (a),
    .multiplier   (b),
    .product_next (prod_next),
    .complete     (mul_complete)
  );

  // The product is taken from the final step's combinational value so it
  // lands in the same edge that drops busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      done <= 1'b0;
      if (accept_single) begin
        done      <= 1'b1;
        result_lo <= alu_lo;
        result_hi <= '0;
        flags     <= alu_flags;
      end else if (mul_complete) begin
        done              <= 1'b1;
        result_lo         <= prod_next[WIDTH-1:0];
        result_hi         <= prod_next[2*WIDTH-1:WIDTH];
        flags             <= '0;
        flags[FLAG_Z]     <= (prod_next == '0);
        flags[FLAG_N]     <= prod_next[2*WIDTH-1];
        flags[FLAG_C]     <= (prod_next[2*WIDTH-1:WIDTH] != '0);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=16: constant vector table,
// model-driven random ops, and hand sequences for multiply corner cases.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset, start, cin;
  logic [4:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  result_lo, result_hi;
  logic [3:0]    flags;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[20];
  int   checks   = 0;
  int   failures = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model written from the arithmetic meaning of each op
  // (signed range for V, borrow/no-borrow for C).
  function automatic exp_t model(input logic [4:0] o, input logic [15:0] x,
                                 input logic [15:0] y, input logic c);
    exp_t   e;
    int     ux, uy, sx, sy, s, ss;
    longint p;
    logic   fc, fv;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    s = 0; ss = 0; fc = 1'b0; fv = 1'b0;
    e.lo = '0; e.hi = '0; e.fl = '0;
    case (o)
      OP_MOV: e.lo = x;
      OP_AND: e.lo = x & y;
      OP_OR:  e.lo = x | y;
      OP_XOR: e.lo = x ^ y;
      OP_INV: e.lo = ~x;
      OP_ADD: begin s = ux + uy; ss = sx + sy; fc = s[16]; end
      OP_ADC: begin s = ux + uy + int'(c); ss = sx + sy + int'(c); fc = s[16]; end
      OP_INC: begin s = ux + 1; ss = sx + 1; fc = s[16]; end
      OP_SUB: begin s = ux - uy; ss = sx - sy; fc = (s >= 0); end
      OP_SBC: begin s = ux - uy - 1 + int'(c); ss = sx - sy - 1 + int'(c); fc = (s >= 0); end
      OP_DEC: begin s = ux - 1; ss = sx - 1; fc = (s >= 0); end
      OP_TWC: begin s = -ux; ss = -sx; fc = (ux == 0); end
      OP_LSR: begin e.lo = x >> 1; fc = x[0]; end
      OP_ASR: begin e.lo = 16'($signed(x) >>> 1); fc = x[0]; end
      default: ;
    endcase
    if (o inside {OP_ADD, OP_ADC, OP_INC, OP_SUB, OP_SBC, OP_DEC, OP_TWC}) begin
      e.lo = s[15:0];
      fv   = (ss > 32767) || (ss < -32768);
    end
    if (o == OP_MULU) begin
      p    = longint'(ux) * longint'(uy);
      e.lo = p[15:0];
      e.hi = p[31:16];
      e.fl = {1'b0, (e.hi != 16'h0), e.hi[15], (p == 0)};
    end else if (o > OP_MULU) begin
      e.fl = 4'b0001;
    end else begin
      e.fl = {fv, fc, e.lo[15], (e.lo == 16'h0)};
    end
    return e;
  endfunction

  task automatic push_exp(input logic [15:0] lo, input logic [15:0] hi, input logic [3:0] fl);
    exp_t e;
    e.lo = lo; e.hi = hi; e.fl = fl;
    exp_q.push_back(e);
  endtask

  // Drives one request, scrambles the operands after the start cycle to
  // prove they were captured, then compares against the scoreboard head.
  task automatic applyStimulus(input string name, input logic [4:0] o, input logic [15:0] x,
                               input logic [15:0] y, input logic c, input int lat);
    int   cyc;
    bit   seen;
    exp_t e;
    op = o; a = x; b = y; cin = c; start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        op    = OP_MOV;
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = ~cin;
      end
      if (done) seen = 1;
    end
    check({name, " done_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(cyc), 32'(lat));
    if (exp_q.size() == 0) begin
      check({name, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput(name, e);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    check({name, " result_lo"}, 32'(result_lo), 32'(e.lo));
    check({name, " result_hi"}, 32'(result_hi), 32'(e.hi));
    check({name, " flags"},     32'(flags),     32'(e.fl));
  endtask

  initial begin
    exp_t e;
    int   pulses;
    logic [4:0]  ro;
    logic [15:0] rx, ry;
    logic        rc;

    vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 4'b1010, 1};
    vecs[1]  = '{OP_SUB,  16'h0005, 16'h0005, 1'b0, 16'h0000, 16'h0000, 4'b0101, 1};
    vecs[2]  = '{OP_SBC,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 4'b0010, 1};
    vecs[3]  = '{OP_LSR,  16'h8001, 16'h0000, 1'b0, 16'h4000, 16'h0000, 4'b0100, 1};
    vecs[4]  = '{OP_ASR,  16'h8001, 16'h0000, 1'b0, 16'hC000, 16'h0000, 4'b0110, 1};
    vecs[5]  = '{5'd20,   16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000, 4'b0001, 1};
    vecs[6]  = '{OP_MOV,  16'h1234, 16'hFFFF, 1'b0, 16'h1234, 16'h0000, 4'b0000, 1};
    vecs[7]  = '{OP_AND,  16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 16'h0000, 4'b0010, 1};
    vecs[8]  = '{OP_OR,   16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 16'h0000, 4'b0000, 1};
    vecs[9]  = '{OP_XOR,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 16'h0000, 4'b0001, 1};
    vecs[10] = '{OP_INV,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 4'b0010, 1};
    vecs[11] = '{OP_TWC,  16'h0001, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 4'b0010, 1};
    vecs[12] = '{OP_TWC,  16'h8000, 16'h0000, 1'b0, 16'h8000, 16'h0000, 4'b1010, 1};
    vecs[13] = '{OP_INC,  16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0000, 4'b0101, 1};
    vecs[14] = '{OP_DEC,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 4'b0010, 1};
    vecs[15] = '{OP_ADC,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'h0000, 4'b0101, 1};
    vecs[16] = '{OP_ADD,  16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h0000, 4'b1101, 1};
    vecs[17] = '{OP_MULU, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 4'b0110, 17};
    vecs[18] = '{OP_MULU, 16'h0000, 16'h1234, 1'b0, 16'h0000, 16'h0000, 4'b0001, 17};
    vecs[19] = '{OP_SUB,  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 4'b0010, 1};

    reset = 1'b1; start = 1'b0; op = OP_MOV; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset busy",      32'(busy),      32'd0);
    check("reset done",      32'(done),      32'd0);
    check("reset result_lo", 32'(result_lo), 32'd0);
    check("reset result_hi", 32'(result_hi), 32'd0);
    check("reset flags",     32'(flags),     32'd0);

    for (int i = 0; i < 20; i++) begin
      push_exp(vecs[i].lo, vecs[i].hi, vecs[i].fl);
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].cin, vecs[i].lat);
    end

    for (int i = 0; i < 25; i++) begin
      ro = (i % 5 == 0) ? OP_MULU : 5'($urandom_range(0, 20));
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
      e  = model(ro, rx, ry, rc);
      exp_q.push_back(e);
      applyStimulus($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry, rc,
                    (ro == OP_MULU) ? 17 : 1);
    end

    // Multiply with an ignored start in cycle 4, then back-to-back ADD.
    op = OP_MULU; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      check($sformatf("mulbusy c%0d busy_done", cyc), 32'({busy, done}), 32'b10);
      start = 1'b0;
      if (cyc == 4) begin
        start = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
      end
    end
    start = 1'b0;
    tick();
    check("mulbusy c17 busy_done", 32'({busy, done}), 32'b01);
    push_exp(16'h0001, 16'hFFFE, 4'b0110);
    e = exp_q.pop_front();
    checkOutput("mulbusy product", e);
    op = OP_ADD; a = 16'h0002; b = 16'h0003; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b add done", 32'(done), 32'd1);
    push_exp(16'h0005, 16'h0000, 4'b0000);
    e = exp_q.pop_front();
    checkOutput("b2b add", e);
    tick();
    check("b2b no_extra_done", 32'(done), 32'd0);
    check("b2b hold lo", 32'(result_lo), 32'h0005);

    // Reset during cycle 5 of a multiply aborts it without a done pulse.
    op = OP_MULU; a = 16'h1234; b = 16'h5678; start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy",      32'(busy),      32'd0);
    check("abort done",      32'(done),      32'd0);
    check("abort result_lo", 32'(result_lo), 32'd0);
    check("abort result_hi", 32'(result_hi), 32'd0);
    check("abort flags",     32'(flags),     32'd0);
    pulses = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (done) pulses++;
    end
    check("abort no_done_pulses", 32'(pulses), 32'd0);
    push_exp(16'h0015, 16'h0000, 4'b0000);
    applyStimulus("mul3x7", OP_MULU, 16'h0003, 16'h0007, 1'b0, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
